rv4028_bus_master: RTL and testbench

Parametrised external-bus master for the RV4028 core family. Accepts one internal word transfer at a time over a valid/ready request port and executes it as one or more RV4028 bus beats of `BUS_W` bits, with byte-mask beat skipping, programmable minimum wait states, `wait_n` stretching and `busrq_n`/`busack_n` bus release. It sits between the core and the FPGA top, whose DDR output cells consume the two-phase strobe pairs and whose tristate buffers consume `data_oe`/`busack_n`.

---
 rtl/rv4028_bus_pkg.sv | 18 +
 rtl/rv4028_bus_beat.sv | 50 +++++
 rtl/rv4028_bus_master.sv | 228 ++++++++++++++++++++++
 tb/tb_rv4028_bus_master.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv4028_bus_pkg.sv
// Shared types and strobe encodings for the RV4028 external bus master.
// Two-bit strobes carry {second half-cycle, first half-cycle} for the DDR output cells.
package rv4028_bus_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_T1,
      S_T2,
      S_TW,
      S_DONE,
      S_HOLD
   } state_t;

   localparam logic [1:0] STB_OFF  = 2'b11;
   localparam logic [1:0] STB_LATE = 2'b01;
   localparam logic [1:0] STB_ON   = 2'b00;

endpackage

// File: rtl/rv4028_bus_beat.sv
// T1/T2/TW beat sequencer: tracks the bus phase of the current beat and
// decides at which edge the beat ends (wait_n high and forced waits spent).
module rv4028_bus_beat
   import rv4028_bus_pkg::*;
#(
   parameter int MIN_WAIT = 0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_start,
   input  logic i_wait_n,
   output logic o_end
);

   localparam logic [3:0] WAIT_LD = 4'(MIN_WAIT);

   state_t     r_phase;
   logic [3:0] r_wcnt;
   logic       w_end;

   // Forced waits run in parallel with wait_n, so they overlap rather than add
   assign w_end = ((r_phase == S_T2) || (r_phase == S_TW)) && i_wait_n && (r_wcnt == 4'd0);
   assign o_end = w_end;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_phase <= S_IDLE;
         r_wcnt  <= 4'd0;
      end else begin
         case (r_phase)
            S_T1: begin
               r_phase <= S_T2;
               r_wcnt  <= WAIT_LD;
            end
            S_T2, S_TW: begin
               if (w_end) begin
                  r_phase <= i_start ? S_T1 : S_IDLE;
               end else begin
                  r_phase <= S_TW;
                  if (r_wcnt != 4'd0) r_wcnt <= r_wcnt - 4'd1;
               end
            end
            default: begin
               if (i_start) r_phase <= S_T1;
            end
         endcase
      end
   end

endmodule

// File: rtl/rv4028_bus_master.sv
// RV4028 external-bus master: splits one internal word transfer into BUS_W beats,
// skipping beats whose byte mask is empty, and releases the bus on busrq_n.
module rv4028_bus_master
   import rv4028_bus_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int BUS_W    = 16,
   parameter int XFER_W   = 32,
   parameter int MIN_WAIT = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_W-1:0]     req_addr,
   input  logic [XFER_W-1:0]     req_wdata,
   input  logic [XFER_W/8-1:0]   req_mask,
   output logic                  rsp_valid,
   output logic [XFER_W-1:0]     rsp_rdata,
   output logic [ADDR_W-1:0]     addr_out,
   output logic [BUS_W-1:0]      data_out,
   input  logic [BUS_W-1:0]      data_in,
   output logic                  data_oe,
   output logic                  rd_n,
   output logic [1:0]            wr_n,
   output logic [1:0]            mreq_n,
   output logic [BUS_W/8-1:0]    msk_n,
   output logic                  iorq_n,
   output logic                  lo_addr,
   input  logic                  wait_n,
   input  logic                  busrq_n,
   output logic                  busack_n
);

   localparam int BEATS   = XFER_W / BUS_W;
   localparam int LANES   = BUS_W / 8;
   localparam int XBYTES  = XFER_W / 8;
   localparam int IDX_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int ALIGN_W = $clog2(XBYTES);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~((ADDR_W'(1) << ALIGN_W) - ADDR_W'(1));

   state_t              r_state;
   logic                r_live;
   logic                r_write;
   logic [ADDR_W-1:0]   r_base;
   logic [XFER_W-1:0]   r_wdata;
   logic [XBYTES-1:0]   r_mask;
   logic [IDX_W-1:0]    r_idx;
   logic                r_rsp_valid;
   logic [XFER_W-1:0]   r_rdata;
   logic [ADDR_W-1:0]   r_addr_out;
   logic [BUS_W-1:0]    r_data_out;
   logic                r_data_oe;
   logic                r_rd_n;
   logic [1:0]          r_wr_n;
   logic [1:0]          r_mreq_n;
   logic [LANES-1:0]    r_msk_n;
   logic                r_iorq_n;
   logic                r_busack_n;

   logic                w_accept;
   logic                w_end;
   logic                w_start;
   logic [IDX_W:0]      w_first;
   logic [IDX_W:0]      w_nxt;
   logic [IDX_W-1:0]    w_ld_idx;
   logic [ADDR_W-1:0]   w_ld_base;
   logic [ADDR_W-1:0]   w_ld_addr;
   logic [XBYTES-1:0]   w_ld_mask;
   logic [XFER_W-1:0]   w_ld_wdata;
   logic                w_ld_write;
   logic [LANES-1:0]    w_ld_lmask;
   logic [BUS_W-1:0]    w_ld_wlane;

   // Returns {found, index} of the lowest beat at or above 'from' with any active byte
   function automatic logic [IDX_W:0] find_beat(input logic [XBYTES-1:0] mask, input int from);
      logic [IDX_W:0] res;
      res = '0;
      for (int i = BEATS - 1; i >= 0; i--) begin
         if ((i >= from) && (|mask[i*LANES +: LANES])) res = {1'b1, IDX_W'(i)};
      end
      return res;
   endfunction

   function automatic logic [BUS_W-1:0] lane_bits(input logic [LANES-1:0] m_n);
      logic [BUS_W-1:0] b;
      for (int j = 0; j < LANES; j++) b[j*8 +: 8] = {8{~m_n[j]}};
      return b;
   endfunction

   // r_live keeps req_ready low while reset is held and on the first edge after it
   assign req_ready = (r_state == S_IDLE) && busrq_n && r_live;
   assign w_accept  = req_valid && req_ready;

   assign w_first = find_beat(req_mask, 0);
   assign w_nxt   = find_beat(r_mask, int'(r_idx) + 1);
   assign w_start = (w_accept && w_first[IDX_W]) || (w_end && w_nxt[IDX_W]);

   // Beat load source: the incoming request on accept, the latched request between beats
   assign w_ld_idx   = w_accept ? w_first[IDX_W-1:0] : w_nxt[IDX_W-1:0];
   assign w_ld_base  = w_accept ? (req_addr & ALIGN_MASK) : r_base;
   assign w_ld_mask  = w_accept ? req_mask : r_mask;
   assign w_ld_wdata = w_accept ? req_wdata : r_wdata;
   assign w_ld_write = w_accept ? req_write : r_write;
   assign w_ld_addr  = w_ld_base + ADDR_W'(int'(w_ld_idx) * LANES);
   assign w_ld_lmask = w_ld_mask[int'(w_ld_idx)*LANES +: LANES];
   assign w_ld_wlane = w_ld_wdata[int'(w_ld_idx)*BUS_W +: BUS_W];

   rv4028_bus_beat #(
      .MIN_WAIT (MIN_WAIT)
   ) u_beat (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_start  (w_start),
      .i_wait_n (wait_n),
      .o_end    (w_end)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_live      <= 1'b0;
         r_write     <= 1'b0;
         r_base      <= '0;
         r_wdata     <= '0;
         r_mask      <= '0;
         r_idx       <= '0;
         r_rsp_valid <= 1'b0;
         r_rdata     <= '0;
         r_addr_out  <= '0;
         r_data_out  <= '0;
         r_data_oe   <= 1'b0;
         r_rd_n      <= 1'b1;
         r_wr_n      <= STB_OFF;
         r_mreq_n    <= STB_OFF;
         r_msk_n     <= '1;
         r_iorq_n    <= 1'b1;
         r_busack_n  <= 1'b1;
      end else begin
         r_live      <= 1'b1;
         r_rsp_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (!busrq_n) begin
                  r_state    <= S_HOLD;
                  r_busack_n <= 1'b0;
               end else if (w_accept) begin
                  r_write <= req_write;
                  r_base  <= req_addr & ALIGN_MASK;
                  r_wdata <= req_wdata;
                  r_mask  <= req_mask;
                  r_rdata <= '0;
                  r_idx   <= w_ld_idx;
                  if (w_first[IDX_W]) begin
                     r_state <= S_T1;
                  end else begin
                     r_state     <= S_DONE;
                     r_rsp_valid <= 1'b1;
                  end
               end
            end
            S_T1: begin
               r_state  <= S_T2;
               r_mreq_n <= STB_ON;
               if (r_write) r_wr_n <= STB_ON;
            end
            S_T2, S_TW: begin
               if (w_end) begin
                  if (!r_write) r_rdata[int'(r_idx)*BUS_W +: BUS_W] <= data_in & lane_bits(r_msk_n);
                  if (w_nxt[IDX_W]) begin
                     r_state <= S_T1;
                     r_idx   <= w_ld_idx;
                  end else begin
                     r_state     <= S_DONE;
                     r_rsp_valid <= 1'b1;
                     r_rd_n      <= 1'b1;
                     r_wr_n      <= STB_OFF;
                     r_mreq_n    <= STB_OFF;
                     r_msk_n     <= '1;
                     r_iorq_n    <= 1'b1;
                     r_data_oe   <= 1'b0;
                  end
               end else begin
                  r_state <= S_TW;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            S_HOLD: begin
               if (busrq_n) begin
                  r_state    <= S_IDLE;
                  r_busack_n <= 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
         // T1 of a new beat: mreq_n asserts mid-cycle, leaving a half-cycle gap between beats
         if (w_start) begin
            r_addr_out <= w_ld_addr;
            r_msk_n    <= ~w_ld_lmask;
            r_iorq_n   <= ~w_ld_addr[ADDR_W-1];
            r_mreq_n   <= STB_LATE;
            r_wr_n     <= STB_OFF;
            r_rd_n     <= w_ld_write;
            r_data_oe  <= w_ld_write;
            if (w_ld_write) r_data_out <= w_ld_wlane;
         end
      end
   end

   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rdata;
   assign addr_out  = r_addr_out;
   assign data_out  = r_data_out;
   assign data_oe   = r_data_oe;
   assign rd_n      = r_rd_n;
   assign wr_n      = r_wr_n;
   assign mreq_n    = r_mreq_n;
   assign msk_n     = r_msk_n;
   assign iorq_n    = r_iorq_n;
   assign lo_addr   = ~|r_addr_out[ADDR_W-1:ADDR_W-8];
   assign busack_n  = r_busack_n;

endmodule

// File: tb/tb_rv4028_bus_master.sv
// Directed bench for rv4028_bus_master: vector table of single transfers plus
// sequences for wait stretching, bus release and reset during a beat.
module tb_rv4028_bus_master;
   import rv4028_bus_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0, req_valid2 = 1'b0;
   logic        req_write = 1'b0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic [3:0]  req_mask = '0;
   logic        wait_n = 1'b1, wait_n2 = 1'b1, busrq_n = 1'b1;
   logic [15:0] d0 = '0, d1 = '0;

   logic        req_ready, rsp_valid, data_oe, rd_n, iorq_n, lo_addr, busack_n;
   logic [31:0] rsp_rdata, addr_out;
   logic [15:0] data_out, data_in;
   logic [1:0]  wr_n, mreq_n, msk_n;

   logic        req_ready2, rsp_valid2, data_oe2, rd_n2, iorq_n2, lo_addr2, busack_n2;
   logic [31:0] rsp_rdata2, addr_out2;
   logic [15:0] data_out2, data_in2;
   logic [1:0]  wr_n2, mreq_n2, msk_n2;

   int tests = 0;
   int fails = 0;

   assign data_in  = addr_out[1]  ? d1 : d0;
   assign data_in2 = addr_out2[1] ? d1 : d0;

   always #5 clk = ~clk;

   rv4028_bus_master dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_mask(req_mask),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .addr_out(addr_out), .data_out(data_out),
      .data_in(data_in), .data_oe(data_oe), .rd_n(rd_n), .wr_n(wr_n), .mreq_n(mreq_n),
      .msk_n(msk_n), .iorq_n(iorq_n), .lo_addr(lo_addr), .wait_n(wait_n),
      .busrq_n(busrq_n), .busack_n(busack_n)
   );

   rv4028_bus_master #(.MIN_WAIT(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid2), .req_ready(req_ready2),
      .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_mask(req_mask),
      .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2), .addr_out(addr_out2), .data_out(data_out2),
      .data_in(data_in2), .data_oe(data_oe2), .rd_n(rd_n2), .wr_n(wr_n2), .mreq_n(mreq_n2),
      .msk_n(msk_n2), .iorq_n(iorq_n2), .lo_addr(lo_addr2), .wait_n(wait_n2),
      .busrq_n(busrq_n), .busack_n(busack_n2)
   );

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  mask;
      logic [15:0] v0;
      logic [15:0] v1;
      int          cyc;
      int          beats;
      logic [31:0] rdata;
      logic [31:0] addr0;
      logic [1:0]  mskn0;
      logic        chk_dout;
      logic [15:0] dout0;
      logic        iorq0;
      logic        lo0;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, " req_ready"}, {31'd0, req_ready}, 32'd0);
      check({tag, " rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
      check({tag, " rsp_rdata"}, rsp_rdata, 32'd0);
      check({tag, " addr_out"}, addr_out, 32'd0);
      check({tag, " data_out"}, {16'd0, data_out}, 32'd0);
      check({tag, " data_oe"}, {31'd0, data_oe}, 32'd0);
      check({tag, " rd_n"}, {31'd0, rd_n}, 32'd1);
      check({tag, " wr_n"}, {30'd0, wr_n}, 32'd3);
      check({tag, " mreq_n"}, {30'd0, mreq_n}, 32'd3);
      check({tag, " msk_n"}, {30'd0, msk_n}, 32'd3);
      check({tag, " iorq_n"}, {31'd0, iorq_n}, 32'd1);
      check({tag, " busack_n"}, {31'd0, busack_n}, 32'd1);
   endtask

   // One transfer on dut; cycle n is the n-th clock period after the accept edge
   task automatic xfer(input int k, input vec_t v);
      int          rcyc, beats;
      logic        got_t2;
      logic [31:0] a0, rd;
      logic [1:0]  m0, wrn1;
      logic [15:0] do0;
      logic        i0, l0, oe0, rdn0;
      string       t;
      t = $sformatf("vec%0d", k);
      rcyc = -1; beats = 0; got_t2 = 1'b0;
      a0 = '0; rd = '0; m0 = '0; wrn1 = '0; do0 = '0; i0 = 1'b0; l0 = 1'b0; oe0 = 1'b0; rdn0 = 1'b0;
      d0 = v.v0; d1 = v.v1;
      @(negedge clk);
      req_valid = 1'b1; req_write = v.wr; req_addr = v.addr; req_wdata = v.wdata; req_mask = v.mask;
      #1 check({t, " ready"}, {31'd0, req_ready}, 32'd1);
      @(posedge clk);
      for (int n = 1; n <= 40 && rcyc < 0; n++) begin
         @(negedge clk);
         if (n == 1) req_valid = 1'b0;
         if (mreq_n == STB_LATE) begin
            if (beats == 0) begin
               a0 = addr_out; m0 = msk_n; do0 = data_out; i0 = iorq_n; l0 = lo_addr;
               oe0 = data_oe; rdn0 = rd_n;
            end
            beats++;
         end else if (mreq_n == STB_ON && beats == 1 && !got_t2) begin
            wrn1 = wr_n; got_t2 = 1'b1;
         end
         if (rsp_valid) begin
            rcyc = n; rd = rsp_rdata;
         end
      end
      check({t, " rsp_cycle"}, rcyc, v.cyc);
      check({t, " beats"}, beats, v.beats);
      check({t, " rdata"}, rd, v.rdata);
      if (v.beats > 0) begin
         check({t, " addr0"}, a0, v.addr0);
         check({t, " msk_n0"}, {30'd0, m0}, {30'd0, v.mskn0});
         check({t, " iorq_n"}, {31'd0, i0}, {31'd0, v.iorq0});
         check({t, " lo_addr"}, {31'd0, l0}, {31'd0, v.lo0});
         check({t, " data_oe"}, {31'd0, oe0}, {31'd0, v.wr});
         check({t, " rd_n"}, {31'd0, rdn0}, {31'd0, v.wr});
         check({t, " wr_n_t2"}, {30'd0, wrn1}, v.wr ? 32'd0 : 32'd3);
         if (v.chk_dout) check({t, " data_out"}, {16'd0, do0}, {16'd0, v.dout0});
      end
   endtask

   // Single read beat on the MIN_WAIT=2 instance, wait_n low for 'low' cycles from T2
   task automatic wait_seq(input int low, input int exp_busy, input int exp_rsp);
      int          rcyc, busy;
      logic [31:0] rd;
      string       t;
      t = $sformatf("wait%0d", low);
      rcyc = -1; busy = 0; rd = '0;
      d0 = 16'h4321; d1 = 16'h9999;
      @(negedge clk);
      req_valid2 = 1'b1; req_write = 1'b0; req_addr = 32'h0; req_mask = 4'b0011;
      #1 check({t, " ready"}, {31'd0, req_ready2}, 32'd1);
      @(posedge clk);
      for (int n = 1; n <= 40 && rcyc < 0; n++) begin
         @(negedge clk);
         if (n == 1) req_valid2 = 1'b0;
         wait_n2 = !(n >= 2 && n < 2 + low);
         if (mreq_n2 != STB_OFF) busy++;
         if (rsp_valid2) begin
            rcyc = n; rd = rsp_rdata2;
         end
      end
      wait_n2 = 1'b1;
      check({t, " busy_cycles"}, busy, exp_busy);
      check({t, " rsp_cycle"}, rcyc, exp_rsp);
      check({t, " rdata"}, rd, 32'h0000_4321);
   endtask

   initial begin : main
      int rcyc, cnt;
      logic [31:0] rd;

      //          wr    addr          wdata         mask     v0       v1       cyc beats rdata         addr0         mskn0  chk   dout      iorq  lo
      vecs[0] = '{1'b0, 32'h0000_1000, 32'h0,        4'hF,    16'h1234, 16'hABCD, 5, 2, 32'hABCD_1234, 32'h0000_1000, 2'b00, 1'b0, 16'h0,    1'b1, 1'b1};
      vecs[1] = '{1'b1, 32'h0000_1000, 32'hDEADBEEF, 4'b1100, 16'h0,    16'h0,    3, 1, 32'h0,         32'h0000_1002, 2'b00, 1'b1, 16'hDEAD, 1'b1, 1'b1};
      vecs[2] = '{1'b1, 32'h0000_1000, 32'hCAFEF00D, 4'b0000, 16'h0,    16'h0,    1, 0, 32'h0,         32'h0,         2'b11, 1'b0, 16'h0,    1'b1, 1'b1};
      vecs[3] = '{1'b0, 32'h8000_0010, 32'h0,        4'b0011, 16'h5566, 16'h7788, 3, 1, 32'h0000_5566, 32'h8000_0010, 2'b00, 1'b0, 16'h0,    1'b0, 1'b0};
      vecs[4] = '{1'b0, 32'h0000_0010, 32'h0,        4'b0100, 16'h1111, 16'h77AB, 3, 1, 32'h00AB_0000, 32'h0000_0012, 2'b10, 1'b0, 16'h0,    1'b1, 1'b1};
      vecs[5] = '{1'b1, 32'h0000_0013, 32'h11223344, 4'b0001, 16'h0,    16'h0,    3, 1, 32'h0,         32'h0000_0010, 2'b10, 1'b1, 16'h3344, 1'b1, 1'b1};
      vecs[6] = '{1'b0, 32'h0000_0020, 32'h0,        4'b1001, 16'hA1B2, 16'hC3D4, 5, 2, 32'hC300_00B2, 32'h0000_0020, 2'b10, 1'b0, 16'h0,    1'b1, 1'b1};

      repeat (3) @(posedge clk);
      #1 check_reset("reset");
      @(negedge clk) rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int k = 0; k < 7; k++) xfer(k, vecs[k]);

      wait_seq(0, 4, 5);
      wait_seq(3, 5, 6);
      wait_seq(5, 7, 8);

      // Bus request wins over a simultaneous transfer request
      @(negedge clk);
      busrq_n = 1'b0; req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h40; req_mask = 4'hF;
      d0 = 16'h1111; d1 = 16'h2222;
      #1 check("hold ready_low", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
      check("hold busack", {31'd0, busack_n}, 32'd0);
      check("hold ready", {31'd0, req_ready}, 32'd0);
      check("hold mreq_n", {30'd0, mreq_n}, 32'd3);
      check("hold data_oe", {31'd0, data_oe}, 32'd0);
      @(negedge clk);
      check("hold busack2", {31'd0, busack_n}, 32'd0);
      busrq_n = 1'b1;
      @(negedge clk);
      check("release busack", {31'd0, busack_n}, 32'd1);
      check("release ready", {31'd0, req_ready}, 32'd1);
      rcyc = -1; rd = '0;
      @(posedge clk);
      for (int n = 1; n <= 40 && rcyc < 0; n++) begin
         @(negedge clk);
         if (n == 1) req_valid = 1'b0;
         if (rsp_valid) begin
            rcyc = n; rd = rsp_rdata;
         end
      end
      check("release rsp_cycle", rcyc, 5);
      check("release rdata", rd, 32'h2222_1111);

      // Reset while the beat is stretched in TW
      @(negedge clk);
      wait_n = 1'b0; req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0; req_mask = 4'b0011;
      @(posedge clk);
      @(negedge clk) req_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("tw mreq_n", {30'd0, mreq_n}, 32'd0);
      rst_n = 1'b0;
      #1 check_reset("midreset");
      @(negedge clk);
      rst_n = 1'b1; wait_n = 1'b1;
      cnt = 0;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         if (rsp_valid) cnt++;
      end
      check("midreset no_rsp", cnt, 0);
      xfer(7, vecs[0]);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
